// File: rtl/i2s_dac_transmitter.sv
// ---------------------------------------------------------------------------
// i2s_dac_transmitter
//
// DAC-side I2S serializer. Parallel stereo pairs enter through a valid/ready
// write port and wait in a small pair FIFO. Each channel word is shifted out
// MSB-first on AUD_DACDAT. The codec is bit-clock and LR-clock master, so
// AUD_BCLK and AUD_DACLRCK are sampled in the clk domain. All serial activity
// happens on the clk cycle that sees a synchronized BCLK falling edge.
//
// Ports
//   clk                     system clock, at least 4x the AUD_BCLK rate
//   reset                   asynchronous active-low reset
//   AUD_BCLK                codec bit clock (asynchronous to clk)
//   AUD_DACLRCK             codec DAC LR clock, low = left, high = right
//   left_channel_audio_in   left sample of the pair being written
//   right_channel_audio_in  right sample of the pair being written
//   write                   write valid
//   write_ready             FIFO can accept a pair
//   clear_underflow         single-cycle clear of the underflow flag
//   AUD_DACDAT              serial DAC data
//   fifo_count              pairs currently stored
//   underflow               sticky: a left frame started with the FIFO empty
// ---------------------------------------------------------------------------
module i2s_dac_transmitter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  input  logic [DATA_WIDTH-1:0]         left_channel_audio_in,
  input  logic [DATA_WIDTH-1:0]         right_channel_audio_in,
  input  logic                          write,
  output logic                          write_ready,
  input  logic                          clear_underflow,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATA_WIDTH;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] DW_C    = BW'(DATA_WIDTH);

  // Synchronizers and edge history
  logic            r_bclk_meta;
  logic            r_bclk_sync;
  logic            r_bclk_last;
  logic            r_lr_meta;
  logic            r_lr_sync;
  logic            r_lr_prev;

  // Pair FIFO
  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_write_ready;

  // Serializer
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_dacdat;
  logic                  r_underflow;

  // Combinational helpers
  logic                  w_bclk_fall;
  logic                  w_lr_change;
  logic                  w_frame_start;
  logic                  w_left_start;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [EW-1:0]         w_head;
  logic [CW-1:0]         w_count_nxt;
  logic [AW-1:0]         w_wr_ptr_nxt;
  logic [AW-1:0]         w_rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_shreg_nxt;
  logic [DATA_WIDTH-1:0] w_hold_nxt;
  logic [BW-1:0]         w_bit_cnt_nxt;
  logic                  w_dacdat_nxt;
  logic                  w_underflow_nxt;
  logic                  w_lr_prev_nxt;

  // Two-flop synchronizers for the codec clocks plus the BCLK edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_meta <= 1'b0;
      r_bclk_sync <= 1'b0;
      r_bclk_last <= 1'b0;
      r_lr_meta   <= 1'b0;
      r_lr_sync   <= 1'b0;
    end else begin
      r_bclk_meta <= AUD_BCLK;
      r_bclk_sync <= r_bclk_meta;
      r_bclk_last <= r_bclk_sync;
      r_lr_meta   <= AUD_DACLRCK;
      r_lr_sync   <= r_lr_meta;
    end
  end

  // Event decode: BCLK fall, channel start, FIFO handshakes
  always_comb begin
    w_bclk_fall   = r_bclk_last & ~r_bclk_sync;
    w_lr_change   = (r_lr_sync != r_lr_prev);
    w_frame_start = w_bclk_fall & w_lr_change;
    w_left_start  = w_frame_start & ~r_lr_sync;
    w_fifo_empty  = (r_count == '0);
    // Write acceptance uses the registered ready, so a pop in the same
    // cycle as a full FIFO does not open a slot until the next clk.
    w_push        = write & r_write_ready;
    w_pop         = w_left_start & ~w_fifo_empty;
    w_head        = r_mem[r_rd_ptr];
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO state registers; write_ready is kept registered from next occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_write_ready <= 1'b1;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_write_ready <= (w_count_nxt < DEPTH_C);
    end
  end

  // FIFO storage: one entry holds {left, right}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {left_channel_audio_in, right_channel_audio_in};
    end
  end

  // Serializer next-state: channel start, data bits, idle padding
  always_comb begin
    w_shreg_nxt   = r_shreg;
    w_hold_nxt    = r_hold;
    w_bit_cnt_nxt = r_bit_cnt;
    w_dacdat_nxt  = r_dacdat;
    w_lr_prev_nxt = r_lr_prev;
    if (w_frame_start) begin
      w_lr_prev_nxt = r_lr_sync;
      if (!r_lr_sync) begin
        if (!w_fifo_empty) begin
          w_shreg_nxt = w_head[EW-1:DATA_WIDTH];
          w_hold_nxt  = w_head[DATA_WIDTH-1:0];
        end else begin
          // Empty FIFO: transmit a silent frame on both channels
          w_shreg_nxt = '0;
          w_hold_nxt  = '0;
        end
      end else begin
        w_shreg_nxt = r_hold;
      end
      w_bit_cnt_nxt = DW_C;
      // I2S one-bit delay slot after the LRCK edge
      w_dacdat_nxt  = 1'b0;
    end else if (w_bclk_fall) begin
      w_lr_prev_nxt = r_lr_sync;
      if (r_bit_cnt != '0) begin
        w_dacdat_nxt  = r_shreg[DATA_WIDTH-1];
        w_shreg_nxt   = {r_shreg[DATA_WIDTH-2:0], 1'b0};
        w_bit_cnt_nxt = r_bit_cnt - BW'(1);
      end else begin
        // Slot longer than the word: pad with zeros
        w_dacdat_nxt = 1'b0;
      end
    end else begin
      w_dacdat_nxt = r_dacdat;
    end
  end

  // Underflow flag: set wins over clear, otherwise sticky
  always_comb begin
    w_underflow_nxt = r_underflow;
    if (w_left_start && w_fifo_empty) begin
      w_underflow_nxt = 1'b1;
    end else if (clear_underflow) begin
      w_underflow_nxt = 1'b0;
    end else begin
      w_underflow_nxt = r_underflow;
    end
  end

  // Serializer and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg     <= '0;
      r_hold      <= '0;
      r_bit_cnt   <= '0;
      r_dacdat    <= 1'b0;
      r_lr_prev   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_shreg     <= w_shreg_nxt;
      r_hold      <= w_hold_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_dacdat    <= w_dacdat_nxt;
      r_lr_prev   <= w_lr_prev_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  assign write_ready = r_write_ready;
  assign fifo_count  = r_count;
  assign AUD_DACDAT  = r_dacdat;
  assign underflow   = r_underflow;

endmodule

// File: doc/i2s_dac_transmitter.md
Name: i2s_dac_transmitter

Overview:
- Audio-codec DAC-side serializer. Accepts parallel stereo sample pairs, such as the filter-selector output, through a valid/ready write port and buffers them in a small pair FIFO.
- Shifts each channel out MSB-first on AUD_DACDAT in I2S format. The codec is bit-clock and LR-clock master: AUD_BCLK and AUD_DACLRCK are inputs sampled in the system clock domain.
- Sits between the filter path and the codec pins. It is the transmit counterpart of the path that delivers left/right 32-bit words to the filters.

Parameters:
DATA_WIDTH, 32, bits per channel word, sent MSB first.
FIFO_DEPTH, 4, stereo pairs buffered; power of two, at least 2.

Ports:
clk  input  1  system clock; must be at least 4x the AUD_BCLK frequency.
reset  input  1  asynchronous, active-low reset.
AUD_BCLK  input  1  codec bit clock (asynchronous to clk).
AUD_DACLRCK  input  1  codec DAC LR clock; low = left, high = right.
left_channel_audio_in  input  DATA_WIDTH  left sample of the pair being written.
right_channel_audio_in  input  DATA_WIDTH  right sample of the pair being written.
write  input  1  write valid.
write_ready  output  1  FIFO can accept a pair.
clear_underflow  input  1  single-cycle clear of the underflow flag.
AUD_DACDAT  output  1  serial DAC data.
fifo_count  output  clog2(FIFO_DEPTH)+1  pairs currently stored.
underflow  output  1  sticky: a frame started with the FIFO empty.

Behaviour:
- Reset (async assert, sync release): FIFO empty; fifo_count=0; write_ready=1; underflow=0; AUD_DACDAT=0; shift register, bit counter and right-hold register all 0. Synchronizers and lr_prev reset to 0.
- Synchronization: AUD_BCLK and AUD_DACLRCK each pass through a 2-FF synchronizer. bclk_fall is a one-clk pulse when the synchronized BCLK goes 1->0. All serial activity happens only on bclk_fall cycles.
- Write port:
  - write_ready = (fifo_count < FIFO_DEPTH), from registered state.
  - A pair is accepted when write && write_ready. Both channels are stored as one 2*DATA_WIDTH entry.
  - write while not ready is ignored, with no error.
- Frame start on a bclk_fall where lr_s != lr_prev; update lr_prev <= lr_s.
  - Left start (lr_s=0), FIFO non-empty: pop head. The shift register takes the left word and the hold register takes the right word.
  - Left start, FIFO empty: shift register and hold register both load 0; underflow <= 1.
  - Right start (lr_s=1): shift register loads the hold register. No pop.
  - Any start: bit_cnt <= DATA_WIDTH; AUD_DACDAT <= 0. This is the I2S one-BCLK delay slot.
- Data bits, on a bclk_fall with no LRCK change:
  - If bit_cnt != 0: AUD_DACDAT <= shreg MSB; shreg shifts left 1; bit_cnt decrements.
  - Otherwise AUD_DACDAT <= 0, covering slots longer than DATA_WIDTH.
  - The MSB therefore appears on the 2nd BCLK fall after the LRCK edge, and the codec samples it on the following BCLK rise.
- Short slot: an LRCK change before bit_cnt reaches 0 truncates the word and starts the new channel immediately. No error is flagged.
- Simultaneous write and pop in one clk:
  - Both are performed; fifo_count is unchanged.
  - When full, write_ready=0, so that cycle's write is not accepted even though the pop frees a slot.
  - When empty, the pop sees empty (zero frame, underflow set) and the write is accepted.
- Underflow flag: set has priority over clear_underflow in the same cycle. It stays sticky otherwise.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- Latency: a pair written into an empty FIFO is transmitted starting at the next left start. Its left MSB appears on AUD_DACDAT 2 bclk_fall edges plus at most 3 clk after the synchronized LRCK falling edge.

Test Plan:
1. Reset, then write L=32'hA5000001, R=32'h80000000; run BCLK=clk/8 with 64 BCLK per frame -> after the LRCK fall, DACDAT=0 for 1 BCLK, then bits 1,0,1,0,0,1,0,1,...,1. After the LRCK rise, 0 then 1 followed by 31 zeros. fifo_count 1->0.
2. Write 4 pairs back-to-back with no BCLK running -> fifo_count=4; write_ready=0; a 5th write is ignored. Frames then emit the pairs in order 1..4 and fifo_count returns to 0.
3. No writes, BCLK running -> both channels are all zeros, underflow=1 after the first LRCK fall. clear_underflow pulse -> 0, then 1 again at the next LRCK fall.
4. FIFO full, with write asserted on the exact clk of the left-start pop -> pop occurs, write rejected, fifo_count=3, write_ready=1 on the next clk.
5. Drive 24 BCLK per channel slot with a 32-bit word -> only the first 23 MSBs are sent, and the next channel starts correctly.
6. Assert reset mid-word (bit 10 of the left word) -> AUD_DACDAT=0 and fifo_count=0 immediately. Output resumes cleanly only after the next true LRCK transition.
